// File: rtl/mvm_pkg.sv
// ============================================================
// Module : mvm_pkg
// Brief  : Shared state encoding and helper functions for mvm_tiled
// Rev    : 1.0
// ============================================================
`default_nettype none

package mvm_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] value;
  } sat_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Arithmetic right shift (floor) then clamp into a signed res_w-bit range.
  function automatic sat_t sat_shift(input logic signed [63:0] acc, input int frac,
                                     input int res_w);
    sat_t               s;
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = acc >>> frac;
    hi = (64'sd1 <<< (res_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (res_w - 1));
    if (v > hi) begin
      s.ovf   = 1'b1;
      s.value = hi;
    end else if (v < lo) begin
      s.ovf   = 1'b1;
      s.value = lo;
    end else begin
      s.ovf   = 1'b0;
      s.value = v;
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mvm_lane.sv
// ============================================================
// Module : mvm_lane
// Brief  : One output lane: TILE_COL signed multipliers, adder tree, accumulator
// Rev    : 1.0
// ============================================================
`default_nettype none

module mvm_lane #(
  parameter int TILE_COL = 3,
  parameter int VEC_W    = 8,
  parameter int MAT_W    = 8,
  parameter int ACC_W    = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic [TILE_COL*VEC_W-1:0]  vec,
  input  logic [TILE_COL*MAT_W-1:0]  mat,
  output logic signed [ACC_W-1:0]    acc_next
);

  localparam int C_PW = VEC_W + MAT_W;

  logic signed [C_PW-1:0]  w_prod [TILE_COL];
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_acc;

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < TILE_COL; j++) begin
      w_prod[j] = C_PW'($signed(vec[j*VEC_W +: VEC_W])) *
                  C_PW'($signed(mat[j*MAT_W +: MAT_W]));
      w_sum     = w_sum + ACC_W'(w_prod[j]);
    end
  end

  assign acc_next = r_acc + w_sum;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= acc_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mvm_tiled.sv
// ============================================================
// Module : mvm_tiled
// Brief  : Tiled signed fixed-point matrix-vector multiply with saturation
// Rev    : 1.0
// ============================================================
`default_nettype none

module mvm_tiled
  import mvm_pkg::*;
#(
  parameter int ROWS     = 5,
  parameter int COLS     = 4,
  parameter int VEC_W    = 8,
  parameter int MAT_W    = 8,
  parameter int RES_W    = 8,
  parameter int FRACTION = 4,
  parameter int TILE_ROW = 3,
  parameter int TILE_COL = 3,
  parameter int ACC_W    = VEC_W + MAT_W + clog2(ROWS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         ready,
  input  logic [ROWS*VEC_W-1:0]        vector,
  input  logic [ROWS*COLS*MAT_W-1:0]   matrix,
  output logic [COLS*RES_W-1:0]        result,
  output logic                         valid,
  output logic                         error
);

  localparam int C_G  = ceil_div(COLS, TILE_ROW);
  localparam int C_K  = ceil_div(ROWS, TILE_COL);
  localparam int C_GW = clog2(C_G) + 1;
  localparam int C_KW = clog2(C_K) + 1;

  logic [1:0]                 r_state;
  logic [1:0]                 w_state_next;
  logic [C_GW-1:0]            r_g;
  logic [C_KW-1:0]            r_k;
  logic [ROWS*VEC_W-1:0]      r_vec;
  logic [ROWS*COLS*MAT_W-1:0] r_mat;
  logic [COLS*RES_W-1:0]      r_result;
  logic                       r_error;

  logic                       w_accept;
  logic                       w_run;
  logic                       w_last_k;
  logic                       w_last_g;
  logic                       w_lane_clr;

  logic [TILE_COL*VEC_W-1:0]  w_vec_tile;
  logic [TILE_COL*MAT_W-1:0]  w_mat_tile [TILE_ROW];
  int                         w_col      [TILE_ROW];
  logic [TILE_ROW-1:0]        w_lane_act;
  logic signed [ACC_W-1:0]    w_acc_next [TILE_ROW];
  sat_t                       w_sat      [TILE_ROW];
  logic [RES_W-1:0]           w_res      [TILE_ROW];
  logic [TILE_ROW-1:0]        w_ovf;
  logic                       w_sat_unused;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)                w_state_next = ST_RUN;
      ST_RUN:  if (w_last_g && w_last_k) w_state_next = ST_DONE;
      ST_DONE:                           w_state_next = ST_IDLE;
      default:                           w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready      = (r_state == ST_IDLE);
    valid      = (r_state == ST_DONE);
    w_run      = (r_state == ST_RUN);
    w_accept   = start && (r_state == ST_IDLE);
    w_last_k   = (r_k == C_KW'(C_K - 1));
    w_last_g   = (r_g == C_GW'(C_G - 1));
    w_lane_clr = w_accept || (w_run && w_last_k);
  end

  // Route the current row chunk / column group onto the lanes; padding reads as zero.
  always_comb begin
    w_vec_tile = '0;
    for (int j = 0; j < TILE_COL; j++) begin
      int r;
      r = int'(r_k) * TILE_COL + j;
      if (r < ROWS) w_vec_tile[j*VEC_W +: VEC_W] = r_vec[r*VEC_W +: VEC_W];
    end
    for (int l = 0; l < TILE_ROW; l++) begin
      int c;
      c             = int'(r_g) * TILE_ROW + l;
      w_col[l]      = c;
      w_lane_act[l] = w_run && (c < COLS);
      w_mat_tile[l] = '0;
      for (int j = 0; j < TILE_COL; j++) begin
        int r;
        r = int'(r_k) * TILE_COL + j;
        if (r < ROWS && c < COLS)
          w_mat_tile[l][j*MAT_W +: MAT_W] = r_mat[(r*COLS + c)*MAT_W +: MAT_W];
      end
    end
  end

  generate
    for (genvar l = 0; l < TILE_ROW; l++) begin : g_lane
      mvm_lane #(
        .TILE_COL (TILE_COL),
        .VEC_W    (VEC_W),
        .MAT_W    (MAT_W),
        .ACC_W    (ACC_W)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_lane_clr),
        .en       (w_lane_act[l]),
        .vec      (w_vec_tile),
        .mat      (w_mat_tile[l]),
        .acc_next (w_acc_next[l])
      );
    end
  endgenerate

  always_comb begin
    w_sat_unused = 1'b0;
    for (int l = 0; l < TILE_ROW; l++) begin
      w_sat[l]     = sat_shift({{(64-ACC_W){w_acc_next[l][ACC_W-1]}}, w_acc_next[l]},
                               FRACTION, RES_W);
      w_res[l]     = w_sat[l].value[RES_W-1:0];
      w_ovf[l]     = w_sat[l].ovf && w_lane_act[l];
      w_sat_unused = w_sat_unused ^ (^w_sat[l].value[63:RES_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec    <= '0;
      r_mat    <= '0;
      r_g      <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else if (w_accept) begin
      r_vec    <= vector;
      r_mat    <= matrix;
      r_g      <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else if (w_run) begin
      if (w_last_k) begin
        r_k <= '0;
        r_g <= r_g + C_GW'(1);
        for (int l = 0; l < TILE_ROW; l++) begin
          if (w_lane_act[l]) r_result[w_col[l]*RES_W +: RES_W] <= w_res[l];
        end
        if (|w_ovf) r_error <= 1'b1;
      end else begin
        r_k <= r_k + C_KW'(1);
      end
    end
  end

  assign result = r_result;
  assign error  = r_error;

endmodule

`default_nettype wire

// File: tb/tb_mvm_tiled.sv
// ============================================================
// Module : tb_mvm_tiled
// Brief  : Self-checking bench for mvm_tiled (default tiling and 1x1 tiling)
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_mvm_tiled;

  localparam int ROWS = 5;
  localparam int COLS = 4;

  typedef struct {
    logic [39:0]  vec;
    logic [159:0] mat;
    logic [31:0]  exp_res;
    logic         exp_err;
    int           exp_lat;
  } vec_rec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start0 = 1'b0, start1 = 1'b0;
  logic         ready0, ready1, valid0, valid1, err0, err1;
  logic [39:0]  vec0 = '0, vec1 = '0;
  logic [159:0] mat0 = '0, mat1 = '0;
  logic [31:0]  res0, res1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mvm_tiled dut0 (
    .clk(clk), .rst(rst), .start(start0), .ready(ready0), .vector(vec0),
    .matrix(mat0), .result(res0), .valid(valid0), .error(err0)
  );

  mvm_tiled #(.TILE_ROW(1), .TILE_COL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ready(ready1), .vector(vec1),
    .matrix(mat1), .result(res1), .valid(valid1), .error(err1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [39:0] fill_vec(input int val);
    logic [39:0] v;
    for (int r = 0; r < ROWS; r++) v[r*8 +: 8] = 8'(val);
    return v;
  endfunction

  function automatic logic [159:0] fill_mat(input int val);
    logic [159:0] m;
    for (int i = 0; i < ROWS*COLS; i++) m[i*8 +: 8] = 8'(val);
    return m;
  endfunction

  // Reference: exact integer dot products, floor divide by 2^4, clamp to int8.
  task automatic model(input logic [39:0] v, input logic [159:0] m,
                       output logic [31:0] res, output logic err);
    err = 1'b0;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      longint s, q;
      int a, b;
      s = 0;
      for (int r = 0; r < ROWS; r++) begin
        a = $signed(v[r*8 +: 8]);
        b = $signed(m[(r*COLS + c)*8 +: 8]);
        s += longint'(a * b);
      end
      q = s / 16;
      if ((s % 16 != 0) && (s < 0)) q = q - 1;
      if (q > 127)  begin q = 127;  err = 1'b1; end
      if (q < -128) begin q = -128; err = 1'b1; end
      res[c*8 +: 8] = 8'(q);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel != 0) ? ready1 : ready0;
  endfunction

  function automatic logic vld(input int sel);
    return (sel != 0) ? valid1 : valid0;
  endfunction

  // Called at a negedge; returns at the negedge where valid is seen (or the bound expires).
  task automatic run_job(input int sel, input logic [39:0] v, input logic [159:0] m,
                         output logic [31:0] res, output logic err, output int lat,
                         output logic rdy_at_valid);
    int n;
    n = 0;
    while (!rdy(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'(rdy(sel)), 64'd1);
    if (sel != 0) begin vec1 = v; mat1 = m; start1 = 1'b1; end
    else          begin vec0 = v; mat0 = m; start0 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 0;
    while (!vld(sel) && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res          = (sel != 0) ? res1 : res0;
    err          = (sel != 0) ? err1 : err0;
    rdy_at_valid = rdy(sel);
  endtask

  vec_rec_t    tbl [4];
  logic [31:0] got_res, exp_res;
  logic        got_err, exp_err, rdy_v, seen_valid;
  int          lat;

  initial begin
    logic [39:0]  v;
    logic [159:0] m;

    tbl[0] = '{fill_vec(16),   fill_mat(16),  {4{8'd80}},  1'b0, 4};
    tbl[1] = '{fill_vec(127),  fill_mat(127), {4{8'd127}}, 1'b1, 4};
    tbl[2] = '{fill_vec(-128), fill_mat(127), {4{8'h80}},  1'b1, 4};
    v = '0;
    v[0*8 +: 8] = 8'd16;
    v[4*8 +: 8] = 8'd16;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[(r*COLS + c)*8 +: 8] = 8'(16 * (c + 1));
    tbl[3] = '{v, m, {8'd127, 8'd96, 8'd64, 8'd32}, 1'b1, 4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 64'(ready0), 64'd1);
    check("reset_valid", 64'(valid0), 64'd0);
    check("reset_error", 64'(err0),   64'd0);
    check("reset_result", 64'(res0),  64'd0);

    for (int i = 0; i < 4; i++) begin
      run_job(0, tbl[i].vec, tbl[i].mat, got_res, got_err, lat, rdy_v);
      check($sformatf("tbl%0d_result", i), 64'(got_res), 64'(tbl[i].exp_res));
      check($sformatf("tbl%0d_error", i),  64'(got_err), 64'(tbl[i].exp_err));
      check($sformatf("tbl%0d_latency", i), 64'(lat),    64'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_ready_in_done", i), 64'(rdy_v), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d_valid_one_cycle", i), 64'(valid0), 64'd0);
      check($sformatf("tbl%0d_result_held", i), 64'(res0), 64'(tbl[i].exp_res));
    end

    // start held high through RUN and DONE with different operands: ignored
    start0 = 1'b1;
    vec0   = tbl[0].vec;
    mat0   = tbl[0].mat;
    @(posedge clk);
    @(negedge clk);
    vec0 = tbl[1].vec;
    mat0 = tbl[1].mat;
    lat  = 0;
    while (!valid0 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("busy_start_latency", 64'(lat),  64'd4);
    check("busy_start_result",  64'(res0), 64'(tbl[0].exp_res));
    check("busy_start_error",   64'(err0), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    check("busy_start_back_idle", 64'(ready0), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("busy_start_not_accepted", 64'(ready0), 64'd1);
    check("busy_start_result_kept", 64'(res0), 64'(tbl[0].exp_res));

    // Reset two cycles into RUN, after the first column group has saturated
    start0 = 1'b1;
    vec0   = tbl[1].vec;
    mat0   = tbl[1].mat;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("abort_pre_error", 64'(err0), 64'd1);
    check("abort_pre_partial", 64'(res0[7:0]), 64'd127);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready",  64'(ready0), 64'd1);
    check("abort_result", 64'(res0),   64'd0);
    check("abort_error",  64'(err0),   64'd0);
    check("abort_valid",  64'(valid0), 64'd0);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (valid0) seen_valid = 1'b1;
    end
    check("abort_no_valid", 64'(seen_valid), 64'd0);
    run_job(0, tbl[0].vec, tbl[0].mat, got_res, got_err, lat, rdy_v);
    check("abort_recover_result",  64'(got_res), 64'(tbl[0].exp_res));
    check("abort_recover_latency", 64'(lat), 64'd4);

    // 1x1 tiling
    run_job(1, tbl[0].vec, tbl[0].mat, got_res, got_err, lat, rdy_v);
    check("tile1_result",  64'(got_res), 64'(tbl[0].exp_res));
    check("tile1_error",   64'(got_err), 64'd0);
    check("tile1_latency", 64'(lat),     64'd20);
    run_job(1, tbl[3].vec, tbl[3].mat, got_res, got_err, lat, rdy_v);
    check("tile1_pad_result", 64'(got_res), 64'(tbl[3].exp_res));
    check("tile1_pad_error",  64'(got_err), 64'd1);

    // Random operands against the reference model
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = (i % 6 == 5) ? 1 : 0;
      for (int r = 0; r < ROWS; r++)
        v[r*8 +: 8] = (i % 2 == 0) ? 8'(int'($urandom_range(0, 40)) - 20)
                                   : 8'($urandom_range(0, 255));
      for (int k = 0; k < ROWS*COLS; k++)
        m[k*8 +: 8] = (i % 2 == 0) ? 8'(int'($urandom_range(0, 40)) - 20)
                                   : 8'($urandom_range(0, 255));
      model(v, m, exp_res, exp_err);
      run_job(sel, v, m, got_res, got_err, lat, rdy_v);
      check($sformatf("rand%0d_result", i), 64'(got_res), 64'(exp_res));
      check($sformatf("rand%0d_error", i),  64'(got_err), 64'(exp_err));
      check($sformatf("rand%0d_latency", i), 64'(lat), (sel != 0) ? 64'd20 : 64'd4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
